// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between core writeback (priority) and a loader port.
// Define RF_INIT_SWEEP_EN to zero registers 1-31 after reset before entering RUN.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,
    output logic        core_stall,
    input  logic        ld_valid,
    input  logic [4:0]  ld_wa,
    input  logic [31:0] ld_wd,
    output logic        ld_ready,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    output logic        init_done
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

`ifdef RF_INIT_SWEEP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, RUN = 2'd2} state_t;
    logic [4:0] sweep_addr;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd2} state_t;
`endif

    state_t     state, state_next;
    logic [3:0] starve_cnt, starve_next;
    logic       forced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

`ifdef RF_INIT_SWEEP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sweep_addr <= 5'd1;
        else if (state == SWEEP)
            sweep_addr <= sweep_addr + 5'd1;
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
`ifdef RF_INIT_SWEEP_EN
            IDLE:    state_next = SWEEP;
            SWEEP:   if (sweep_addr == 5'd31) state_next = RUN;
`else
            IDLE:    state_next = RUN;
`endif
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    assign forced = (state == RUN) && ld_valid && (starve_cnt == LIMIT);

    // Count only cycles where the loader asks and is refused; any transfer or idle loader resets it.
    always_comb begin
        starve_next = starve_cnt;
        if (state == RUN) begin
            if (!ld_valid || ld_ready)
                starve_next = 4'd0;
            else if (starve_cnt < LIMIT)
                starve_next = starve_cnt + 4'd1;
        end
    end

    always_comb begin
        we3        = 1'b0;
        wa3        = 5'd0;
        wd3        = 32'd0;
        core_stall = 1'b0;
        ld_ready   = 1'b0;
        init_done  = 1'b0;
        case (state)
            IDLE: core_stall = 1'b1;
`ifdef RF_INIT_SWEEP_EN
            SWEEP: begin
                we3        = 1'b1;
                wa3        = sweep_addr;
                core_stall = 1'b1;
            end
`endif
            RUN: begin
                init_done = 1'b1;
                if (forced) begin
                    core_stall = 1'b1;
                    ld_ready   = 1'b1;
                    wa3        = ld_wa;
                    wd3        = ld_wd;
                    we3        = (ld_wa != 5'd0);
                end else if (wb_we) begin
                    wa3 = wb_wa;
                    wd3 = wb_wd;
                    we3 = (wb_wa != 5'd0);
                end else if (ld_valid) begin
                    ld_ready = 1'b1;
                    wa3      = ld_wa;
                    wd3      = ld_wd;
                    we3      = (ld_wa != 5'd0);
                end
            end
            default: core_stall = 1'b1;
        endcase
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Write-port arbiter and initialiser for the 32×32 register file. The register file has one write port (`we3`/`wa3`/`wd3`), and this block shares it between two requesters. The core writeback path has priority; the loader/debug port uses a valid/ready handshake. A starvation counter guarantees loader progress by stalling the core. An optional post-reset sweep writes zero to registers 1–31 so that every register, including `cr`/`hr`/`fp`, starts at a known value.

## Interface
- `STARVE_LIMIT`, default 4: consecutive denied loader cycles before the loader is force-granted. Legal range 1–15.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `wb_we`  in  1  core writeback request.
- `wb_wa`  in  5  core writeback address.
- `wb_wd`  in  32  core writeback data.
- `core_stall`  out  1  core must hold its writeback (and pipeline) this cycle.
- `ld_valid`  in  1  loader request.
- `ld_wa`  in  5  loader address.
- `ld_wd`  in  32  loader data.
- `ld_ready`  out  1  loader transfer accepted at the next rising edge when `ld_valid` is also high.
- `we3`  out  1  register-file write enable.
- `wa3`  out  5  register-file write address.
- `wd3`  out  32  register-file write data.
- `init_done`  out  1  high in RUN.

## Operation
- **States:** IDLE, SWEEP, RUN. Reset value is IDLE, with sweep address = 1 and starve count = 0.
- **IDLE outputs:** `we3`=0, `wa3`=0, `wd3`=0, `core_stall`=1, `ld_ready`=0, `init_done`=0. IDLE always lasts exactly one cycle after reset release.
- **SWEEP outputs:** `we3`=1, `wa3`=sweep address, `wd3`=0, `core_stall`=1, `ld_ready`=0.
  - The sweep address increments every edge.
  - After the edge that writes address 31, go to RUN.
- **RUN arbitration (combinational, evaluated each cycle):**
  - **Forced cycle** (starve count == `STARVE_LIMIT` and `ld_valid`): grant the loader, `core_stall`=1.
  - **Core write** (else if `wb_we`): grant the core, `core_stall`=0, `ld_ready`=0.
  - **Loader write** (else if `ld_valid`): grant the loader, `ld_ready`=1, `core_stall`=0.
  - **No request:** `we3`=0, `wa3`=0, `wd3`=0, `core_stall`=0.
  - In a forced cycle the core write is not performed. The core must re-present it the next cycle.
- **Grant outputs:** `wa3`/`wd3` come from the granted requester. `we3`=1 unless the granted address is 0.
- **Address 0:** writes to address 0 are dropped (`we3`=0). The requester still completes: the core is not stalled, the loader gets `ld_ready`=1.
- **Starve count:**
  - Increments on each RUN edge where `ld_valid`=1 and `ld_ready`=0.
  - Clears on a loader transfer or whenever `ld_valid`=0.
  - Saturates at `STARVE_LIMIT`.
- **Loader handshake:** once `ld_valid` is raised, `ld_wa`/`ld_wd` are held stable until transfer.

## Timing
- **Write latency:** zero added. Grant and port outputs are combinational from registered state plus inputs. The register file captures the write at the same rising edge that completes the request.
- **Sweep schedule (relative to the first edge after `rst_n` rises):**
  - Edge 0: IDLE→SWEEP.
  - Edges 1–31: write registers 1–31.
  - Edge 31: enter RUN; `init_done`=1 from then on.
- **Worst-case loader wait:** `STARVE_LIMIT` denied cycles, then transfer on the next cycle.
- **Reset mid-operation:** `rst_n` low forces IDLE immediately (asynchronous). This restarts the sweep from address 1 and clears the starve count. No partial write occurs after reset assertion, because IDLE has `we3`=0.

## Configuration
- **`RF_INIT_SWEEP_EN` defined:** IDLE→SWEEP→RUN as above.
- **`RF_INIT_SWEEP_EN` undefined:**
  - IDLE→RUN directly; `init_done` rises one edge after reset release.
  - The SWEEP state and sweep counter are not built.
  - Register contents after reset are whatever the register file holds.

## Test plan
- **Reset sweep (macro on):** release `rst_n` → one IDLE cycle, then 31 cycles with `we3`=1, `wa3`=1..31, `wd3`=0, `core_stall`=1, `ld_ready`=0; then `init_done`=1 and a readback of regs 1, 4, 30 gives 0.
- **Core write:** RUN, `wb_we`=1, `wb_wa`=5, `wb_wd`=100, `ld_valid`=0 → same cycle `we3`=1, `wa3`=5, `wd3`=100, `core_stall`=0; reg 5 reads 100.
- **Loader write:** `wb_we`=0, `ld_valid`=1, `ld_wa`=30, `ld_wd`=303 → `ld_ready`=1, `wa3`=30, `wd3`=303; `fp` reads 303; starve count stays 0.
- **Starvation:** `STARVE_LIMIT`=4, `wb_we`=1 every cycle (`wb_wa`=7, `wb_wd`=200), `ld_valid`=1, `ld_wa`=4, `ld_wd`=202 →
  - Cycles 1–4: `ld_ready`=0, `wa3`=7.
  - Cycle 5: `ld_ready`=1, `core_stall`=1, `wa3`=4, `wd3`=202.
  - Cycle 6: `core_stall`=0, `wa3`=7.
- **Address 0:** `wb_wa`=0, `wb_wd`=102 → `we3`=0, `core_stall`=0. Then loader `ld_wa`=0 → `ld_ready`=1, `we3`=0. Reg 0 reads 0 throughout.
- **Reset mid-sweep:** assert `rst_n` low while `wa3`=10 → `we3`=0 immediately; after release the sweep restarts at `wa3`=1 and completes all 31 writes.
